// File: rtl/vx_issue_scoreboard.sv
// ---------------------------------------------------------------------------
// vx_issue_scoreboard
//   Per-slice issue stage. Sits between the per-warp instruction buffers and
//   operand collection. A busy bit per (warp, register) tracks in-flight
//   destination registers. A warp whose head instruction would read a busy
//   register (RAW) or overwrite one (WAW) is held back. One eligible warp is
//   granted per cycle, round-robin. Busy bits are released when the last beat
//   (eop) of a writeback packet arrives.
//
// Optional feature macro: VX_SCB_PERF_EN
//   When defined, adds the perf_stalls output. It is a saturating count of
//   cycles in which some warp had a valid head, the output register could
//   accept, and every valid head was blocked by the scoreboard.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   ibuf_valid/ready  per-warp head valid / one-hot dequeue (zero in reset)
//   ibuf_wb, ibuf_rd  head writes rd / destination register (RW bits per warp)
//   ibuf_rs1/2/3      source registers (RW bits per warp, unused driven 0)
//   ibuf_data         opaque payload (DATAW bits per warp)
//   wb_valid/wid/rd/eop  writeback beat; only eop beats release a register
//   out_valid/ready   registered issue output with pass-through ready
//   out_wid/rd/wb/data  issued warp id, rd, wb flag and payload
//   perf_stalls       scoreboard stall cycles (only with VX_SCB_PERF_EN)
// ---------------------------------------------------------------------------
module vx_issue_scoreboard #(
  parameter int NUM_WARPS  = 4,
  parameter int NUM_REGS   = 64,
  parameter int DATAW      = 128,
  parameter bit R0_ZERO    = 1'b1,
  parameter int PERF_CTR_W = 44,
  localparam int WIDW      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int RW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_WARPS-1:0]       ibuf_valid,
  output logic [NUM_WARPS-1:0]       ibuf_ready,
  input  logic [NUM_WARPS-1:0]       ibuf_wb,
  input  logic [NUM_WARPS*RW-1:0]    ibuf_rd,
  input  logic [NUM_WARPS*RW-1:0]    ibuf_rs1,
  input  logic [NUM_WARPS*RW-1:0]    ibuf_rs2,
  input  logic [NUM_WARPS*RW-1:0]    ibuf_rs3,
  input  logic [NUM_WARPS*DATAW-1:0] ibuf_data,
  input  logic                       wb_valid,
  input  logic [WIDW-1:0]            wb_wid,
  input  logic [RW-1:0]              wb_rd,
  input  logic                       wb_eop,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDW-1:0]            out_wid,
  output logic [RW-1:0]              out_rd,
  output logic                       out_wb,
  output logic [DATAW-1:0]           out_data
`ifdef VX_SCB_PERF_EN
  ,
  output logic [PERF_CTR_W-1:0]      perf_stalls
`endif
);

  // Elaboration-time sanity check on the configuration.
  if (NUM_WARPS < 1 || NUM_REGS < 2 || DATAW < 1 || PERF_CTR_W < 1) begin : g_param_check
    $error("vx_issue_scoreboard: illegal parameter combination");
  end

  logic [NUM_WARPS-1:0][NUM_REGS-1:0] busy;
  logic [WIDW-1:0]      rr_ptr;
  logic [NUM_WARPS-1:0] eligible;
  logic                 can_issue;
  logic                 grant_any;
  logic [WIDW-1:0]      grant_wid;
  logic                 issue;
  logic [RW-1:0]        grant_rd;
  logic                 grant_wb;
  int unsigned          scan_idx;

  // Eligibility looks only at registered busy bits; a writeback landing this
  // cycle unblocks a warp on the following cycle, never the same one.
  always_comb begin
    eligible = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      eligible[w] = ibuf_valid[w]
                  & ~busy[w][ibuf_rs1[w*RW +: RW]]
                  & ~busy[w][ibuf_rs2[w*RW +: RW]]
                  & ~busy[w][ibuf_rs3[w*RW +: RW]]
                  & ~(ibuf_wb[w] & busy[w][ibuf_rd[w*RW +: RW]]);
    end
  end

  assign can_issue = ~out_valid | out_ready;

  // Round-robin scan. Walking the offsets from the far end down to zero lets
  // the eligible warp closest to rr_ptr be the last (winning) assignment.
  always_comb begin
    grant_any = 1'b0;
    grant_wid = '0;
    scan_idx  = 0;
    for (int i = NUM_WARPS - 1; i >= 0; i--) begin
      scan_idx = (int'(rr_ptr) + i) % NUM_WARPS;
      if (eligible[scan_idx]) begin
        grant_any = 1'b1;
        grant_wid = WIDW'(scan_idx);
      end
    end
  end

  assign issue      = can_issue & grant_any & ~reset;
  assign ibuf_ready = issue ? (NUM_WARPS'(1) << grant_wid) : '0;
  assign grant_rd   = ibuf_rd[grant_wid*RW +: RW];
  assign grant_wb   = ibuf_wb[grant_wid];

  // Scoreboard, arbiter pointer and output register. The set is written after
  // the clear so that a same-cycle set and clear of one bit leaves it busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= '0;
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_wid   <= '0;
      out_rd    <= '0;
      out_wb    <= 1'b0;
      out_data  <= '0;
    end else begin
      if (wb_valid && wb_eop && (int'(wb_wid) < NUM_WARPS)) begin
        busy[wb_wid][wb_rd] <= 1'b0;
      end
      if (issue) begin
        if (grant_wb && !(R0_ZERO && (grant_rd == '0))) begin
          busy[grant_wid][grant_rd] <= 1'b1;
        end
        if (NUM_WARPS == 1) begin
          rr_ptr <= '0;
        end else if (int'(grant_wid) == NUM_WARPS - 1) begin
          rr_ptr <= '0;
        end else begin
          rr_ptr <= grant_wid + 1'b1;
        end
      end
      if (can_issue) begin
        out_valid <= grant_any;
        if (grant_any) begin
          out_wid  <= grant_wid;
          out_rd   <= grant_rd;
          out_wb   <= grant_wb;
          out_data <= ibuf_data[grant_wid*DATAW +: DATAW];
        end
      end
    end
  end

`ifdef VX_SCB_PERF_EN
  logic stall_cycle;

  assign stall_cycle = (|ibuf_valid) & ~(|eligible) & can_issue;

  // Saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stalls <= '0;
    end else if (stall_cycle && (perf_stalls != '1)) begin
      perf_stalls <= perf_stalls + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_issue_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_vx_issue_scoreboard
//   Directed self-checking bench for vx_issue_scoreboard at its default
//   configuration (4 warps, 64 registers, 128-bit payload, R0 hardwired).
//   Inputs change 1 time unit after a rising edge; registered outputs are
//   sampled there and combinational ibuf_ready is sampled after its inputs
//   settle. The perf counter steps run only when VX_SCB_PERF_EN is defined.
// ---------------------------------------------------------------------------
module tb_vx_issue_scoreboard;
  localparam int NW = 4;
  localparam int RW = 6;
  localparam int DW = 128;

  logic             clk = 1'b0;
  logic             reset;
  logic [NW-1:0]    ibuf_valid;
  logic [NW-1:0]    ibuf_ready;
  logic [NW-1:0]    ibuf_wb;
  logic [NW*RW-1:0] ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3;
  logic [NW*DW-1:0] ibuf_data;
  logic             wb_valid;
  logic [1:0]       wb_wid;
  logic [RW-1:0]    wb_rd;
  logic             wb_eop;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_wid;
  logic [RW-1:0]    out_rd;
  logic             out_wb;
  logic [DW-1:0]    out_data;
`ifdef VX_SCB_PERF_EN
  logic [43:0]      perf_stalls;
`endif

  int checks = 0;
  int errors = 0;

  vx_issue_scoreboard dut (
    .clk        (clk),
    .reset      (reset),
    .ibuf_valid (ibuf_valid),
    .ibuf_ready (ibuf_ready),
    .ibuf_wb    (ibuf_wb),
    .ibuf_rd    (ibuf_rd),
    .ibuf_rs1   (ibuf_rs1),
    .ibuf_rs2   (ibuf_rs2),
    .ibuf_rs3   (ibuf_rs3),
    .ibuf_data  (ibuf_data),
    .wb_valid   (wb_valid),
    .wb_wid     (wb_wid),
    .wb_rd      (wb_rd),
    .wb_eop     (wb_eop),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_wid    (out_wid),
    .out_rd     (out_rd),
    .out_wb     (out_wb),
    .out_data   (out_data)
`ifdef VX_SCB_PERF_EN
    ,
    .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_warp(input int w, input bit v, input bit wb, input int rd,
                          input int rs1, input int rs2, input int rs3, input int data);
    ibuf_valid[w]          = v;
    ibuf_wb[w]             = wb;
    ibuf_rd[w*RW +: RW]    = RW'(rd);
    ibuf_rs1[w*RW +: RW]   = RW'(rs1);
    ibuf_rs2[w*RW +: RW]   = RW'(rs2);
    ibuf_rs3[w*RW +: RW]   = RW'(rs3);
    ibuf_data[w*DW +: DW]  = DW'(data);
  endtask

  task automatic clear_warps();
    ibuf_valid = '0;
    ibuf_wb    = '0;
    ibuf_rd    = '0;
    ibuf_rs1   = '0;
    ibuf_rs2   = '0;
    ibuf_rs3   = '0;
    ibuf_data  = '0;
  endtask

  task automatic drive_wb(input bit v, input int wid, input int rd, input bit eop);
    wb_valid = v;
    wb_wid   = 2'(wid);
    wb_rd    = RW'(rd);
    wb_eop   = eop;
  endtask

  task automatic check_output(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    clear_warps();
    drive_wb(1'b0, 0, 0, 1'b0);

    // Reset: ready held low even with a valid head, outputs cleared.
    set_warp(0, 1, 0, 0, 0, 0, 0, 'h11);
    settle();
    check_output("reset_ready", 128'(ibuf_ready), 128'h0);
    tick();
    tick();
    check_output("reset_valid", 128'(out_valid), 128'h0);
    check_output("reset_wid",   128'(out_wid),   128'h0);
    check_output("reset_rd",    128'(out_rd),    128'h0);
    check_output("reset_data",  out_data,        128'h0);
    clear_warps();
    reset = 1'b0;
    tick();

    // RAW: w0 writes r5, then reads r5 and waits for the eop writeback.
    set_warp(0, 1, 1, 5, 0, 0, 0, 'hA0);
    settle();
    check_output("raw_first_ready", 128'(ibuf_ready), 128'h1);
    tick();
    check_output("raw_first_valid", 128'(out_valid), 128'h1);
    check_output("raw_first_rd",    128'(out_rd),    128'h5);
    check_output("raw_first_wb",    128'(out_wb),    128'h1);
    check_output("raw_first_data",  out_data,        128'hA0);
    set_warp(0, 1, 0, 6, 5, 0, 0, 'hB0);
    settle();
    check_output("raw_blocked", 128'(ibuf_ready), 128'h0);
    drive_wb(1'b1, 0, 5, 1'b1);
    settle();
    check_output("raw_no_bypass", 128'(ibuf_ready), 128'h0);
    tick();
    drive_wb(1'b0, 0, 0, 1'b0);
    check_output("raw_bubble", 128'(out_valid), 128'h0);
    settle();
    check_output("raw_released", 128'(ibuf_ready), 128'h1);
    tick();
    check_output("raw_second_wid",  128'(out_wid), 128'h0);
    check_output("raw_second_data", out_data,      128'hB0);
    clear_warps();
    tick();
    check_output("raw_idle", 128'(out_valid), 128'h0);

    // Round robin from a freshly reset pointer: 0,1,2,3,0.
    apply_reset();
    for (int w = 0; w < NW; w++) set_warp(w, 1, 0, 0, 0, 0, 0, 'h100 + w);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output($sformatf("rr_wid_%0d", i), 128'(out_wid), 128'(i % NW));
      check_output($sformatf("rr_data_%0d", i), out_data, 128'(32'h100 + (i % NW)));
    end

    // Backpressure: output holds w0/0x100, nothing dequeued for 5 cycles.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check_output($sformatf("bp_ready_%0d", i), 128'(ibuf_ready), 128'h0);
      tick();
      check_output($sformatf("bp_valid_%0d", i), 128'(out_valid), 128'h1);
      check_output($sformatf("bp_data_%0d", i),  out_data,        128'h100);
    end
    out_ready = 1'b1;
    settle();
    check_output("bp_release_ready", 128'(ibuf_ready), 128'h2);
    tick();
    check_output("bp_release_wid", 128'(out_wid), 128'h1);
    clear_warps();
    tick();

    // R0 hardwired: w1 writes r0 then reads r0 back to back.
    set_warp(1, 1, 1, 0, 0, 0, 0, 'hC0);
    settle();
    check_output("r0_first_ready", 128'(ibuf_ready), 128'h2);
    tick();
    check_output("r0_first_wb", 128'(out_wb), 128'h1);
    set_warp(1, 1, 0, 0, 0, 0, 0, 'hD0);
    settle();
    check_output("r0_second_ready", 128'(ibuf_ready), 128'h2);
    tick();
    check_output("r0_second_data", out_data, 128'hD0);
    clear_warps();
    tick();

    // EOP: w2 writes r7, then reads it via rs2; eop=0 beat does not release.
    set_warp(2, 1, 1, 7, 0, 0, 0, 'hE0);
    settle();
    check_output("eop_first_ready", 128'(ibuf_ready), 128'h4);
    tick();
    set_warp(2, 1, 0, 0, 0, 7, 0, 'hF0);
    drive_wb(1'b1, 2, 7, 1'b0);
    tick();
    drive_wb(1'b0, 0, 0, 1'b0);
    settle();
    check_output("eop0_still_blocked", 128'(ibuf_ready), 128'h0);
    check_output("eop0_out_idle", 128'(out_valid), 128'h0);
    drive_wb(1'b1, 2, 7, 1'b1);
    tick();
    drive_wb(1'b0, 0, 0, 1'b0);
    settle();
    check_output("eop1_released", 128'(ibuf_ready), 128'h4);
    tick();
    check_output("eop1_data", out_data, 128'hF0);
    clear_warps();
    tick();

    // Same-cycle set and clear of busy[3][9]: the set must win.
    set_warp(3, 1, 1, 9, 0, 0, 0, 'h90);
    drive_wb(1'b1, 3, 9, 1'b1);
    settle();
    check_output("setclr_ready", 128'(ibuf_ready), 128'h8);
    tick();
    drive_wb(1'b0, 0, 0, 1'b0);
    set_warp(3, 1, 0, 0, 0, 0, 9, 'h91);
    settle();
    check_output("setclr_still_busy", 128'(ibuf_ready), 128'h0);
    drive_wb(1'b1, 3, 9, 1'b1);
    tick();
    drive_wb(1'b0, 0, 0, 1'b0);
    settle();
    check_output("setclr_released", 128'(ibuf_ready), 128'h8);
    tick();
    clear_warps();
    tick();

    // WAW: w0 rewriting busy r12 is skipped and w1 is granted instead.
    set_warp(0, 1, 1, 12, 0, 0, 0, 'h120);
    settle();
    check_output("waw_first_ready", 128'(ibuf_ready), 128'h1);
    tick();
    set_warp(0, 1, 1, 12, 0, 0, 0, 'h121);
    set_warp(1, 1, 0, 0, 0, 0, 0, 'h122);
    settle();
    check_output("waw_skip_ready", 128'(ibuf_ready), 128'h2);
    tick();
    check_output("waw_skip_wid", 128'(out_wid), 128'h1);
    clear_warps();
    tick();

`ifdef VX_SCB_PERF_EN
    // Perf: three hazard-stalled cycles, then reset clears the counter.
    apply_reset();
    check_output("perf_reset", 128'(perf_stalls), 128'h0);
    set_warp(0, 1, 1, 5, 0, 0, 0, 'h50);
    tick();
    set_warp(0, 1, 0, 0, 5, 0, 0, 'h51);
    tick();
    tick();
    tick();
    check_output("perf_three", 128'(perf_stalls), 128'h3);
    clear_warps();
    apply_reset();
    check_output("perf_cleared", 128'(perf_stalls), 128'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
